tx_queue: RTL and testbench

TX_QUEUE -- requirements
Module: tx_queue

---
 rtl/tx_queue.sv | 154 +++++++++++++++
 tb/tb_tx_queue.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_queue.sv
// tx_queue: circular-buffer transmit queue that hands its head item to a serial tx stage via req/tx_busy.
// Optional statistics outputs (sent_count, retry_count) are enabled by defining TXQ_STATS_EN.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

module tx_queue #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  push,
  input  logic [`PAYLOAD_SIZE+`ADDR_BITS-1:0]   item_in,
  output logic                                  full,
  output logic                                  empty,
  output logic [$clog2(DEPTH+1)-1:0]            count,
  input  logic                                  tx_busy,
  output logic                                  req,
  output logic [`PAYLOAD_SIZE+`ADDR_BITS-1:0]   parallel_out
`ifdef TXQ_STATS_EN
  ,
  output logic [15:0]                           sent_count,
  output logic [7:0]                            retry_count
`endif
);

  localparam int unsigned IW = `PAYLOAD_SIZE + `ADDR_BITS;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [7:0]  TIMEOUT_W = 8'(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_ACCEPT,
    ST_WAIT_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      wait_q, wait_d;
  logic [7:0]      wait_inc;
  logic [IW-1:0]   mem_q [DEPTH];
  logic            push_acc;
  logic            pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return p + PW'(1);
  endfunction

  // full is judged on the registered count, so a same-cycle pop never frees room for a push
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign push_acc = push && !full;
  assign pop      = (state_q == ST_WAIT_DONE) && !tx_busy;
  assign wait_inc = wait_q + 8'd1;

  assign req          = (state_q == ST_REQ);
  assign parallel_out = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty && !tx_busy) state_d = ST_REQ;
      end
      ST_REQ: begin
        state_d = ST_WAIT_ACCEPT;
        wait_d  = '0;
      end
      ST_WAIT_ACCEPT: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
          wait_d  = '0;
        end else if (wait_inc == TIMEOUT_W) begin
          state_d = ST_REQ;
          wait_d  = '0;
        end else begin
          wait_d  = wait_inc;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop      ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push_acc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count and the pointers
  always_ff @(posedge clk) begin
    if (push_acc && !reset) mem_q[wr_ptr_q] <= item_in;
  end

`ifdef TXQ_STATS_EN
  logic [15:0] sent_q;
  logic [7:0]  retry_q;
  logic        retry_evt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign retry_evt = (state_q == ST_WAIT_ACCEPT) && !tx_busy && (wait_inc == TIMEOUT_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      sent_q  <= '0;
      retry_q <= '0;
    end else begin
      if (pop)       sent_q  <= sent_q + 16'd1;
      if (retry_evt) retry_q <= sat_inc8(retry_q);
    end
  end

  assign sent_count  = sent_q;
  assign retry_count = retry_q;
`endif

endmodule

// File: tb/tb_tx_queue.sv
// tb_tx_queue: randomized and directed bench for tx_queue with a queue-based reference model and a tx-stage responder.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

module tb_tx_queue;
  localparam int DEPTH = 4;
  localparam int ACK   = 8;
  localparam int IW    = `PAYLOAD_SIZE + `ADDR_BITS;
  localparam int CW    = $clog2(DEPTH + 1);
  typedef logic [IW-1:0] item_t;

  logic          clk = 1'b0;
  logic          reset, push, tx_busy;
  item_t         item_in, parallel_out;
  logic          full, empty, req;
  logic [CW-1:0] count;
`ifdef TXQ_STATS_EN
  logic [15:0]   sent_count;
  logic [7:0]    retry_count;
`endif

  tx_queue #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK)) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .item_in      (item_in),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .tx_busy      (tx_busy),
    .req          (req),
    .parallel_out (parallel_out)
`ifdef TXQ_STATS_EN
    ,
    .sent_count   (sent_count),
    .retry_count  (retry_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: FIFO contents plus the cycle numbers at which a req and a pop are due
  item_t mq[$];
  int    cyc       = 0;
  int    exp_req   = -1;
  int    pop_at    = -1;
  int    busy_left = 0;
  bit    in_txn    = 0;
  bit    retry_pend = 0;
`ifdef TXQ_STATS_EN
  int    m_sent  = 0;
  int    m_retry = 0;
`endif

  typedef enum int {M_RESPOND, M_IGNORE, M_HOLD, M_RANDOM} mode_t;
  mode_t mode  = M_RESPOND;
  int    rsp_k = 2;

  // One clock cycle: check outputs at the negedge, play the tx stage, drive inputs, advance the model
  task automatic tick(input bit rst, input bit psh, input item_t it);
    bit    req_now, ign;
    int    k;
    item_t exp_po;
    bit    full_b;
    req_now = (cyc == exp_req);
    if (req_now && retry_pend) begin
      retry_pend = 0;
`ifdef TXQ_STATS_EN
      if (m_retry < 255) m_retry++;
`endif
    end
    exp_po = (mq.size() == 0) ? item_t'(0) : mq[0];
    n_tests++;
    if (req !== req_now) begin
      n_fail++; $display("FAIL req cyc=%0d got=%b want=%b", cyc, req, req_now);
    end
    n_tests++;
    if (count !== CW'(mq.size())) begin
      n_fail++; $display("FAIL count cyc=%0d got=%0d want=%0d", cyc, count, mq.size());
    end
    n_tests++;
    if (empty !== (mq.size() == 0)) begin
      n_fail++; $display("FAIL empty cyc=%0d got=%b want=%b", cyc, empty, mq.size() == 0);
    end
    n_tests++;
    if (full !== (mq.size() == DEPTH)) begin
      n_fail++; $display("FAIL full cyc=%0d got=%b want=%b", cyc, full, mq.size() == DEPTH);
    end
    n_tests++;
    if (parallel_out !== exp_po) begin
      n_fail++; $display("FAIL parallel_out cyc=%0d got=%h want=%h", cyc, parallel_out, exp_po);
    end
`ifdef TXQ_STATS_EN
    n_tests++;
    if (sent_count !== 16'(m_sent)) begin
      n_fail++; $display("FAIL sent_count cyc=%0d got=%0d want=%0d", cyc, sent_count, m_sent);
    end
    n_tests++;
    if (retry_count !== 8'(m_retry)) begin
      n_fail++; $display("FAIL retry_count cyc=%0d got=%0d want=%0d", cyc, retry_count, m_retry);
    end
`endif
    if (rst) begin
      tx_busy = 1'b0; busy_left = 0;
    end else if (req_now) begin
      ign = (mode == M_IGNORE) || (mode == M_RANDOM && $urandom_range(3) == 0);
      k   = (mode == M_RANDOM) ? int'($urandom_range(6, 1)) : rsp_k;
      tx_busy = 1'b0;
      if (ign) begin
        exp_req = cyc + ACK + 1; retry_pend = 1;
      end else begin
        busy_left = k; pop_at = cyc + k + 1;
      end
    end else if (busy_left > 0) begin
      tx_busy = 1'b1; busy_left--;
    end else begin
      tx_busy = (mode == M_HOLD);
    end
    if (!rst && !in_txn && mq.size() > 0 && !tx_busy) begin
      exp_req = cyc + 1; in_txn = 1;
    end
    reset = rst; push = psh; item_in = it;
    @(posedge clk);
    if (rst) begin
      mq.delete(); in_txn = 0; exp_req = -1; pop_at = -1; busy_left = 0; retry_pend = 0;
`ifdef TXQ_STATS_EN
      m_sent = 0; m_retry = 0;
`endif
    end else begin
      full_b = (mq.size() == DEPTH);
      if (psh && !full_b) mq.push_back(it);
      if (cyc == pop_at) begin
        if (mq.size() > 0) void'(mq.pop_front());
`ifdef TXQ_STATS_EN
        m_sent = (m_sent + 1) % 65536;
`endif
        in_txn = 0; pop_at = -1;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; push = 1'b0; item_in = '0; tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (count !== '0)        begin n_fail++; $display("FAIL reset_count got=%0d want=0", count); end
    n_tests++; if (empty !== 1'b1)      begin n_fail++; $display("FAIL reset_empty got=%b want=1", empty); end
    n_tests++; if (full !== 1'b0)       begin n_fail++; $display("FAIL reset_full got=%b want=0", full); end
    n_tests++; if (req !== 1'b0)        begin n_fail++; $display("FAIL reset_req got=%b want=0", req); end
    n_tests++; if (parallel_out !== '0) begin n_fail++; $display("FAIL reset_pout got=%h want=0", parallel_out); end
    tick(1, 0, '0);
  endtask

  task automatic test_latency();
    int nreq;
    mode = M_RESPOND; rsp_k = 5;
    tick(0, 0, '0);
    tick(0, 1, item_t'(1));
    n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL latency_n1 got=%b want=0", req); end
    tick(0, 0, '0);
    n_tests++; if (req !== 1'b1) begin n_fail++; $display("FAIL latency_n2 got=%b want=1", req); end
    n_tests++; if (parallel_out !== item_t'(1)) begin n_fail++; $display("FAIL latency_pout got=%h want=1", parallel_out); end
    n_tests++; if (count !== CW'(1)) begin n_fail++; $display("FAIL latency_count got=%0d want=1", count); end
    nreq = 1;
    repeat (7) begin
      tick(0, 0, '0);
      nreq += int'(req);
    end
    n_tests++; if (nreq != 1) begin n_fail++; $display("FAIL single_req_pulse got=%0d want=1", nreq); end
    n_tests++; if (empty !== 1'b1 || count !== '0) begin n_fail++; $display("FAIL pop_after_busy got=%b/%0d want=1/0", empty, count); end
  endtask

  task automatic test_full_order();
    item_t vals[5];
    item_t got[$];
    for (int i = 0; i < 5; i++) vals[i] = item_t'(10 + i);
    mode = M_HOLD;
    tick(0, 0, '0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_after_4 got=%b want=1", full); end
      end
      tick(0, 1, vals[i]);
    end
    n_tests++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL drop_5th got=%0d want=%0d", count, DEPTH); end
    mode = M_RESPOND; rsp_k = 2;
    for (int i = 0; i < 40; i++) begin
      if (req === 1'b1) got.push_back(parallel_out);
      tick(0, 0, '0);
    end
    n_tests++; if (got.size() != 4) begin n_fail++; $display("FAIL sent_items got=%0d want=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_tests++;
      if (got[i] !== vals[i]) begin n_fail++; $display("FAIL order_%0d got=%h want=%h", i, got[i], vals[i]); end
    end
  endtask

  task automatic test_timeout();
    int  i;
    bit  seen;
    mode = M_IGNORE;
    tick(0, 1, item_t'(7));
    seen = 0;
    for (i = 0; i < 10; i++) begin
      if (req === 1'b1) begin seen = 1; break; end
      tick(0, 0, '0);
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL timeout_first_req got=none want=req"); end
    tick(0, 0, '0);
    for (int j = 1; j < ACK; j++) begin
      n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL timeout_gap_%0d got=%b want=0", j, req); end
      tick(0, 0, '0);
    end
    mode = M_RESPOND; rsp_k = 2;
    n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL timeout_gap_%0d got=%b want=0", ACK, req); end
    tick(0, 0, '0);
    n_tests++; if (req !== 1'b1) begin n_fail++; $display("FAIL retry_req got=%b want=1", req); end
    n_tests++; if (parallel_out !== item_t'(7)) begin n_fail++; $display("FAIL retry_head got=%h want=7", parallel_out); end
`ifdef TXQ_STATS_EN
    n_tests++; if (retry_count !== 8'd1) begin n_fail++; $display("FAIL retry_count1 got=%0d want=1", retry_count); end
`endif
    repeat (6) tick(0, 0, '0);
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL timeout_drain got=%b want=1", empty); end
  endtask

  task automatic test_reset_mid();
    mode = M_RESPOND; rsp_k = 30;
    for (int i = 1; i <= 3; i++) tick(0, 1, item_t'(i));
    repeat (3) tick(0, 0, '0);
    n_tests++; if (count !== CW'(3)) begin n_fail++; $display("FAIL mid_count got=%0d want=3", count); end
    tick(1, 0, '0);
    n_tests++; if (count !== '0 || empty !== 1'b1) begin n_fail++; $display("FAIL mid_reset got=%0d/%b want=0/1", count, empty); end
    n_tests++; if (req !== 1'b0 || parallel_out !== '0) begin n_fail++; $display("FAIL mid_reset_out got=%b/%h want=0/0", req, parallel_out); end
    rsp_k = 2;
    tick(0, 1, item_t'(5));
    tick(0, 0, '0);
    n_tests++; if (req !== 1'b1 || parallel_out !== item_t'(5)) begin n_fail++; $display("FAIL post_reset_send got=%b/%h want=1/5", req, parallel_out); end
    repeat (6) tick(0, 0, '0);
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL post_reset_drain got=%b want=1", empty); end
  endtask

  task automatic test_push_full_pop();
    mode = M_HOLD;
    tick(0, 0, '0);
    for (int i = 0; i < DEPTH; i++) tick(0, 1, item_t'(32 + i));
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL pfp_full got=%b want=1", full); end
    mode = M_RESPOND; rsp_k = 1;
    for (int i = 0; i < 20 && pop_at != cyc; i++) tick(0, 0, '0);
    n_tests++; if (pop_at != cyc) begin n_fail++; $display("FAIL pfp_pop_wait got=none want=pop"); end
    tick(0, 1, item_t'(63));
    n_tests++; if (count !== CW'(DEPTH - 1)) begin n_fail++; $display("FAIL pfp_count got=%0d want=%0d", count, DEPTH - 1); end
    repeat (25) tick(0, 0, '0);
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL pfp_drain got=%b want=1", empty); end
  endtask

  task automatic test_random();
    bit r, p;
    mode = M_RANDOM;
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(199) == 0);
      p = ($urandom_range(9) < 4);
      tick(r, p, item_t'($urandom));
    end
    mode = M_RESPOND; rsp_k = 1;
    for (int i = 0; i < 200 && (mq.size() > 0 || in_txn); i++) tick(0, 0, '0);
    n_tests++; if (empty !== 1'b1 || count !== '0) begin n_fail++; $display("FAIL random_drain got=%b/%0d want=1/0", empty, count); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full_order();
    test_timeout();
    test_reset_mid();
    test_push_full_pop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
